irq_pend_unit: RTL and testbench
================================

// Module: irq_pend_unit
// PURPOSE
// - Upstream feeder of the n_clic interrupt controller.
// - Synchronises VecSize asynchronous external interrupt lines and detects edges or levels per vector.
// - Holds per-vector pending state and drives the pend vector that n_clic's entry pended bits consume.
// - Clears edge pends on the acknowledge n_clic issues when it takes a vector.
// - Flags lost edges (overrun) for software.
// PARAMETERS
// - VecSize     8            number of interrupt vectors (<=32)
// - VecWidth    $clog2(VecSize)  derived, ack index width
// - SyncStages  2            flip-flops in each input synchroniser (>=2)
// - EdgeTrig    '1           VecSize-bit mask: 1 = rising-edge source, 0 = level source
// PORTS
// - clk        in   1         core clock
// - reset      in   1         asynchronous, active-low reset
// - irq_in     in   VecSize   raw external interrupt lines, async to clk
// - sw_set     in   VecSize   one-cycle mask, software pend set (CSR path)
// - sw_clr     in   VecSize   one-cycle mask, software pend/overrun clear
// - ack_valid  in   1         n_clic took an interrupt this cycle
// - ack_vec    in   VecWidth  index of the vector taken
// - pend       out  VecSize   pending vector to n_clic, registered
// - overrun    out  VecSize   sticky: edge arrived while already pending
// - pend_any   out  1         OR of pend, registered
// BEHAVIOUR
// - Reset (reset==0, async): every synchroniser flop, edge-history flop, pend, overrun and pend_any go to 0.
// - Reset takes effect immediately, mid-operation included; in-flight edges are discarded.
// - Synchroniser: sync[k] = irq_in[k] delayed SyncStages clk. prev[k] <= sync[k] every cycle.
// - Edge source (EdgeTrig[k]=1):
//     edge[k] = sync[k] & ~prev[k].
//     Next pend[k], in priority order:
//       1. sw_clr[k]                          -> 0
//       2. edge[k] | sw_set[k]                -> 1
//       3. ack_valid & ack_vec==k             -> 0
//       4. otherwise                          -> hold
//     Consequence: an edge in the same cycle as its own ack stays pended, so no loss.
// - Overrun (edge source):
//     overrun[k] <= 1 when edge[k] & pend[k] & ~(ack_valid & ack_vec==k) & ~sw_clr[k].
//     sw_clr[k] clears overrun[k]; sw_clr wins over a simultaneous set.
//     Ack does not clear overrun.
// - Level source (EdgeTrig[k]=0):
//     pend[k] <= sync[k] each cycle.
//     sw_set, sw_clr and ack are ignored.
//     overrun[k] is constant 0.
// - Latency:
//     irq_in rising (meeting setup) -> pend high on the (SyncStages+1)th rising clk edge.
//     sw_set/sw_clr/ack -> pend updated on the next clk edge.
//     pend_any lags pend by 1 cycle.
// - Ack with ack_vec >= VecSize is ignored. ack_valid=0 ignores ack_vec.
// - Any input held high at reset release: prev=0, so an edge source pends once after SyncStages+1 cycles.
// - A pulse shorter than one clk period may be missed; a pulse must be high for >=1 sampled cycle.
// - Width: all masks are VecSize bits; no arithmetic beyond the index compare (ack_vec zero-extended to 32b).
// TESTING
// - Reset: drive irq_in='1 during reset -> pend, overrun, pend_any all 0. Release -> edge vectors pend at cycle 3.
// - Edge/ack, SyncStages=2: rise irq_in[3] -> pend=8'h08 at cycle 3, pend_any at 4. ack_vec=3 -> pend=0 next cycle.
// - Collision: pend[5]=1, new edge[5] in same cycle as ack_vec=5 -> pend[5] stays 1, overrun[5] stays 0.
// - Overrun: pend[2]=1, second irq_in[2] pulse, no ack -> overrun=8'h04. sw_clr=8'h04 -> pend[2]=0 and overrun[2]=0 next cycle.
// - Level (EdgeTrig=8'hFE), vector 0: irq_in[0] high 10 cycles -> pend[0] high 10 cycles, 3-cycle delay. ack_vec=0 and sw_clr[0] have no effect.
// - Bounds/priority: ack_vec=7 with VecSize=6 -> no change. sw_set=8'h01 and sw_clr=8'h01 together -> pend[0]=0.

Source files
------------

// File: rtl/irq_pend_unit.sv
// rtl/irq_pend_unit.sv - per-vector interrupt synchroniser, edge/level detect and pend/overrun state
module irq_pend_unit #(
    parameter int unsigned        VecSize    = 8,
    parameter int unsigned        VecWidth   = (VecSize > 1) ? $clog2(VecSize) : 1,
    parameter int unsigned        SyncStages = 2,
    parameter logic [VecSize-1:0] EdgeTrig   = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VecSize-1:0]  irq_in,
    input  logic [VecSize-1:0]  sw_set,
    input  logic [VecSize-1:0]  sw_clr,
    input  logic                ack_valid,
    input  logic [VecWidth-1:0] ack_vec,
    output logic [VecSize-1:0]  pend,
    output logic [VecSize-1:0]  overrun,
    output logic                pend_any
);

    logic [SyncStages-1:0][VecSize-1:0] sync_q, sync_d;
    logic [VecSize-1:0]                 prev_q, prev_d;
    logic [VecSize-1:0]                 pend_q, pend_d;
    logic [VecSize-1:0]                 overrun_q, overrun_d;
    logic                               pend_any_q, pend_any_d;

    logic [VecSize-1:0] sync_out;
    logic [VecSize-1:0] edge_det;
    logic [VecSize-1:0] ack_hit;
    logic [VecSize-1:0] edge_pend;

    // Stage 0 samples the raw lines; the last stage is the metastability-safe view.
    always_comb begin
        sync_d   = {sync_q[SyncStages-2:0], irq_in};
        sync_out = sync_q[SyncStages-1];
        prev_d   = sync_out;
        edge_det = sync_out & ~prev_q;
    end

    // Out-of-range indices simply match no vector.
    always_comb begin
        ack_hit = '0;
        if (ack_valid) begin
            for (int unsigned k = 0; k < VecSize; k++) begin
                if (32'(ack_vec) == k) begin
                    ack_hit[k] = 1'b1;
                end
            end
        end
    end

    // Edge pends: clear beats set beats ack, so an edge racing its own ack is kept.
    always_comb begin
        edge_pend  = ~sw_clr & (edge_det | sw_set | (pend_q & ~ack_hit));
        pend_d     = (EdgeTrig & edge_pend) | (~EdgeTrig & sync_out);
        overrun_d  = EdgeTrig & ~sw_clr & (overrun_q | (edge_det & pend_q & ~ack_hit));
        pend_any_d = |pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            overrun_q  <= '0;
            pend_any_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            overrun_q  <= overrun_d;
            pend_any_q <= pend_any_d;
        end
    end

    assign pend     = pend_q;
    assign overrun  = overrun_q;
    assign pend_any = pend_any_q;

endmodule

// File: tb/tb_irq_pend_unit.sv
// tb/tb_irq_pend_unit.sv - directed self-checking bench for irq_pend_unit
`timescale 1ns/1ps
module tb_irq_pend_unit;

    logic clk;
    logic reset;

    logic [7:0] irq_in, sw_set, sw_clr, pend, overrun;
    logic       ack_valid, pend_any;
    logic [2:0] ack_vec;

    logic [7:0] l_irq, l_set, l_clr, l_pend, l_ovr;
    logic       l_ackv, l_any;
    logic [2:0] l_ackvec;

    logic [5:0] s_irq, s_set, s_clr, s_pend, s_ovr;
    logic       s_ackv, s_any;
    logic [2:0] s_ackvec;

    int checks;
    int failures;

    irq_pend_unit dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .sw_set(sw_set), .sw_clr(sw_clr),
        .ack_valid(ack_valid), .ack_vec(ack_vec), .pend(pend), .overrun(overrun), .pend_any(pend_any)
    );

    irq_pend_unit #(.VecSize(8), .SyncStages(2), .EdgeTrig(8'hFE)) dut_lvl (
        .clk(clk), .reset(reset), .irq_in(l_irq), .sw_set(l_set), .sw_clr(l_clr),
        .ack_valid(l_ackv), .ack_vec(l_ackvec), .pend(l_pend), .overrun(l_ovr), .pend_any(l_any)
    );

    irq_pend_unit #(.VecSize(6), .SyncStages(2), .EdgeTrig(6'h3F)) dut6 (
        .clk(clk), .reset(reset), .irq_in(s_irq), .sw_set(s_set), .sw_clr(s_clr),
        .ack_valid(s_ackv), .ack_vec(s_ackvec), .pend(s_pend), .overrun(s_ovr), .pend_any(s_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        irq_in = 8'hFF;
        repeat (3) tick();
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=%h", pend, 8'h00); end
        checks++; if (overrun !== 8'h00) begin failures++; $display("FAIL reset_overrun got=%h exp=%h", overrun, 8'h00); end
        checks++; if (pend_any !== 1'b0) begin failures++; $display("FAIL reset_pend_any got=%b exp=0", pend_any); end
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL release_pend_c2 got=%h exp=%h", pend, 8'h00); end
        tick();
        checks++; if (pend !== 8'hFF) begin failures++; $display("FAIL release_pend_c3 got=%h exp=%h", pend, 8'hFF); end
        checks++; if (pend_any !== 1'b0) begin failures++; $display("FAIL release_any_c3 got=%b exp=0", pend_any); end
        tick();
        checks++; if (pend_any !== 1'b1) begin failures++; $display("FAIL release_any_c4 got=%b exp=1", pend_any); end
        sw_clr = 8'hFF;
        tick();
        sw_clr = 8'h00;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL swclr_all got=%h exp=%h", pend, 8'h00); end
        irq_in = 8'h00;
        repeat (4) tick();
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL fall_no_pend got=%h exp=%h", pend, 8'h00); end
        checks++; if (pend_any !== 1'b0) begin failures++; $display("FAIL fall_no_any got=%b exp=0", pend_any); end
    endtask

    task automatic test_edge_ack;
        irq_in[3] = 1'b1;
        repeat (2) tick();
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL edge3_c2 got=%h exp=%h", pend, 8'h00); end
        tick();
        checks++; if (pend !== 8'h08) begin failures++; $display("FAIL edge3_c3 got=%h exp=%h", pend, 8'h08); end
        checks++; if (pend_any !== 1'b0) begin failures++; $display("FAIL edge3_any_c3 got=%b exp=0", pend_any); end
        tick();
        checks++; if (pend_any !== 1'b1) begin failures++; $display("FAIL edge3_any_c4 got=%b exp=1", pend_any); end
        ack_valid = 1'b1; ack_vec = 3'd3;
        tick();
        ack_valid = 1'b0;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL ack3 got=%h exp=%h", pend, 8'h00); end
        irq_in[3] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_collision;
        irq_in[5] = 1'b1;
        repeat (3) tick();
        checks++; if (pend !== 8'h20) begin failures++; $display("FAIL coll_first got=%h exp=%h", pend, 8'h20); end
        irq_in[5] = 1'b0;
        tick();
        irq_in[5] = 1'b1;
        repeat (2) tick();
        ack_valid = 1'b1; ack_vec = 3'd5;
        tick();
        ack_valid = 1'b0;
        checks++; if (pend !== 8'h20) begin failures++; $display("FAIL coll_pend got=%h exp=%h", pend, 8'h20); end
        checks++; if (overrun !== 8'h00) begin failures++; $display("FAIL coll_overrun got=%h exp=%h", overrun, 8'h00); end
        sw_clr = 8'h20; irq_in[5] = 1'b0;
        tick();
        sw_clr = 8'h00;
        repeat (3) tick();
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL coll_cleanup got=%h exp=%h", pend, 8'h00); end
    endtask

    task automatic test_overrun;
        irq_in[2] = 1'b1;
        repeat (3) tick();
        irq_in[2] = 1'b0;
        tick();
        irq_in[2] = 1'b1;
        repeat (2) tick();
        checks++; if (overrun !== 8'h00) begin failures++; $display("FAIL ovr_early got=%h exp=%h", overrun, 8'h00); end
        tick();
        checks++; if (overrun !== 8'h04) begin failures++; $display("FAIL ovr_set got=%h exp=%h", overrun, 8'h04); end
        checks++; if (pend !== 8'h04) begin failures++; $display("FAIL ovr_pend got=%h exp=%h", pend, 8'h04); end
        ack_valid = 1'b1; ack_vec = 3'd2;
        tick();
        ack_valid = 1'b0;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL ovr_ack_pend got=%h exp=%h", pend, 8'h00); end
        checks++; if (overrun !== 8'h04) begin failures++; $display("FAIL ovr_ack_keeps got=%h exp=%h", overrun, 8'h04); end
        sw_set = 8'h04;
        tick();
        sw_set = 8'h00;
        checks++; if (pend !== 8'h04) begin failures++; $display("FAIL swset2 got=%h exp=%h", pend, 8'h04); end
        sw_clr = 8'h04;
        tick();
        sw_clr = 8'h00;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL swclr2_pend got=%h exp=%h", pend, 8'h00); end
        checks++; if (overrun !== 8'h00) begin failures++; $display("FAIL swclr2_ovr got=%h exp=%h", overrun, 8'h00); end
        irq_in[2] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_priority;
        sw_set = 8'h01;
        tick();
        sw_set = 8'h00;
        checks++; if (pend !== 8'h01) begin failures++; $display("FAIL prio_set got=%h exp=%h", pend, 8'h01); end
        sw_set = 8'h01; sw_clr = 8'h01;
        tick();
        sw_set = 8'h00; sw_clr = 8'h00;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL prio_clr_wins got=%h exp=%h", pend, 8'h00); end
        sw_set = 8'h40; ack_valid = 1'b0; ack_vec = 3'd6;
        tick();
        sw_set = 8'h00;
        tick();
        checks++; if (pend !== 8'h40) begin failures++; $display("FAIL ackvalid0 got=%h exp=%h", pend, 8'h40); end
        sw_clr = 8'h40;
        tick();
        sw_clr = 8'h00;
    endtask

    task automatic test_level;
        logic [7:0] exp;
        l_irq[0] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            l_ackv = (t >= 4 && t <= 6);
            l_ackvec = 3'd0;
            l_clr = (t == 7 || t == 8) ? 8'h01 : 8'h00;
            l_set = (t == 13) ? 8'h01 : 8'h00;
            if (t == 11) l_irq[0] = 1'b0;
            tick();
            exp = (t >= 3 && t <= 12) ? 8'h01 : 8'h00;
            checks++; if (l_pend !== exp) begin failures++; $display("FAIL level_t%0d got=%h exp=%h", t, l_pend, exp); end
            checks++; if (l_ovr !== 8'h00) begin failures++; $display("FAIL level_ovr_t%0d got=%h exp=%h", t, l_ovr, 8'h00); end
        end
        l_ackv = 1'b0; l_clr = 8'h00; l_set = 8'h00;
    endtask

    task automatic test_bounds;
        s_set = 6'h3F;
        tick();
        s_set = 6'h00;
        checks++; if (s_pend !== 6'h3F) begin failures++; $display("FAIL b6_set got=%h exp=%h", s_pend, 6'h3F); end
        s_ackv = 1'b1; s_ackvec = 3'd7;
        tick();
        checks++; if (s_pend !== 6'h3F) begin failures++; $display("FAIL b6_ack7 got=%h exp=%h", s_pend, 6'h3F); end
        s_ackvec = 3'd6;
        tick();
        checks++; if (s_pend !== 6'h3F) begin failures++; $display("FAIL b6_ack6 got=%h exp=%h", s_pend, 6'h3F); end
        s_ackvec = 3'd5;
        tick();
        s_ackv = 1'b0;
        checks++; if (s_pend !== 6'h1F) begin failures++; $display("FAIL b6_ack5 got=%h exp=%h", s_pend, 6'h1F); end
    endtask

    task automatic test_async_reset;
        sw_set = 8'h81;
        tick();
        sw_set = 8'h00;
        tick();
        checks++; if (pend !== 8'h81) begin failures++; $display("FAIL pre_rst_pend got=%h exp=%h", pend, 8'h81); end
        checks++; if (pend_any !== 1'b1) begin failures++; $display("FAIL pre_rst_any got=%b exp=1", pend_any); end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++; if (pend !== 8'h00) begin failures++; $display("FAIL async_rst_pend got=%h exp=%h", pend, 8'h00); end
        checks++; if (pend_any !== 1'b0) begin failures++; $display("FAIL async_rst_any got=%b exp=0", pend_any); end
        checks++; if (s_pend !== 6'h00) begin failures++; $display("FAIL async_rst_b6 got=%h exp=%h", s_pend, 6'h00); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        irq_in = '0; sw_set = '0; sw_clr = '0; ack_valid = 1'b0; ack_vec = '0;
        l_irq = '0; l_set = '0; l_clr = '0; l_ackv = 1'b0; l_ackvec = '0;
        s_irq = '0; s_set = '0; s_clr = '0; s_ackv = 1'b0; s_ackvec = '0;
        #1;
        test_reset();
        test_edge_ack();
        test_collision();
        test_overrun();
        test_priority();
        test_level();
        test_bounds();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
